// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// - Decodes ALUOp/Funct into the 4-bit ALU select code.
// - Forwards operands from the EX stage (the instruction held here) and from
//   the MEM stage.
// - Detects load-use hazards, stalls decode and inserts a bubble.
// - Inserts a bubble on branch flush.
// Optional feature macro: IDEX_PERF_CNT_EN adds stall and flush counters.
// When the macro is undefined, StallCount and FlushCount are tied to 0.
module id_ex_stage #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          InValid,
  input  logic          Flush,
  input  logic [1:0]    ALUOp,
  input  logic [5:0]    Funct,
  input  logic          ALUSrc,
  input  logic [4:0]    CtrlIn,      // {RegWrite, MemRead, MemWrite, MemtoReg, RegDst}
  input  logic [AW-1:0] Rs,
  input  logic [AW-1:0] Rt,
  input  logic [AW-1:0] Rd,
  input  logic [W-1:0]  RsData,
  input  logic [W-1:0]  RtData,
  input  logic [W-1:0]  Imm,
  input  logic [W-1:0]  ExResult,
  input  logic          MemRegWrite,
  input  logic [AW-1:0] MemRd,
  input  logic [W-1:0]  MemResult,
  output logic          Stall,
  output logic          OutValid,
  output logic [W-1:0]  Op1,
  output logic [W-1:0]  Op2,
  output logic [3:0]    Sel,
  output logic [W-1:0]  StoreData,
  output logic [AW-1:0] WriteReg,
  output logic [3:0]    CtrlOut,     // {RegWrite, MemRead, MemWrite, MemtoReg}
  output logic [31:0]   StallCount,
  output logic [31:0]   FlushCount
);

  typedef enum logic [3:0] {
    SEL_AND = 4'b0000,
    SEL_OR  = 4'b0001,
    SEL_ADD = 4'b0010,
    SEL_MUL = 4'b0101,
    SEL_SUB = 4'b0110,
    SEL_SLT = 4'b0111,
    SEL_BAD = 4'b1111
  } alu_sel_e;

  // Bit positions inside CtrlIn.
  localparam int CI_REGWRITE = 4;
  localparam int CI_MEMREAD  = 3;
  localparam int CI_MEMWRITE = 2;
  localparam int CI_REGDST   = 0;
  // Bit positions inside the held control word.
  localparam int CO_REGWRITE = 3;
  localparam int CO_MEMREAD  = 2;

  // Held instruction.
  logic          r_out_valid;
  logic [W-1:0]  r_op1;
  logic [W-1:0]  r_op2;
  logic [3:0]    r_sel;
  logic [W-1:0]  r_store_data;
  logic [AW-1:0] r_write_reg;
  logic [3:0]    r_ctrl;

  logic          w_ex_can_fwd;
  logic          w_held_load;
  logic          w_rt_used;
  logic          w_hazard;
  logic          w_stall;
  logic          w_bubble;
  logic [W-1:0]  w_fwd_a;
  logic [W-1:0]  w_fwd_b;
  alu_sel_e      w_sel;

  // A load's data is not ready in EX, so only non-load writers forward from EX.
  assign w_ex_can_fwd = r_out_valid & r_ctrl[CO_REGWRITE] & ~r_ctrl[CO_MEMREAD];
  assign w_held_load  = r_out_valid & r_ctrl[CO_MEMREAD] & (r_write_reg != '0);
  // Rt is a real source for R-type ops and for stores (store data).
  assign w_rt_used    = ~ALUSrc | CtrlIn[CI_MEMWRITE];
  assign w_hazard     = w_held_load &
                        ((r_write_reg == Rs) | ((r_write_reg == Rt) & w_rt_used));
  assign w_stall      = InValid & w_hazard & ~Flush;
  assign w_bubble     = Flush | w_stall | ~InValid;

  // Operand A forwarding: EX beats MEM, register 0 never forwards.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_fwd_a = RsData;
    if (Rs != '0) begin
      if (w_ex_can_fwd && (r_write_reg == Rs))   w_fwd_a = ExResult;
      else if (MemRegWrite && (MemRd == Rs))     w_fwd_a = MemResult;
    end
  end

  // Operand B forwarding: same priority as operand A.
  always_comb begin
    w_fwd_b = RtData;
    if (Rt != '0) begin
      if (w_ex_can_fwd && (r_write_reg == Rt))   w_fwd_b = ExResult;
      else if (MemRegWrite && (MemRd == Rt))     w_fwd_b = MemResult;
    end
  end

  // ALU select decode from the main-control class and the funct field.
  always_comb begin
    w_sel = SEL_BAD;
    case (ALUOp)
      2'b00: w_sel = SEL_ADD;
      2'b01: w_sel = SEL_SUB;
      2'b11: w_sel = SEL_OR;
      default: begin
        case (Funct)
          6'b100000: w_sel = SEL_ADD;
          6'b100010: w_sel = SEL_SUB;
          6'b100100: w_sel = SEL_AND;
          6'b100101: w_sel = SEL_OR;
          6'b101010: w_sel = SEL_SLT;
          6'b011000: w_sel = SEL_MUL;
          default:   w_sel = SEL_BAD;
        endcase
      end
    endcase
  end

  // Pipeline register: reset, then bubble (flush/stall/idle), else capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst || w_bubble) begin
      r_out_valid  <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_sel        <= '0;
      r_store_data <= '0;
      r_write_reg  <= '0;
      r_ctrl       <= '0;
    end else begin
      r_out_valid  <= 1'b1;
      r_op1        <= w_fwd_a;
      r_op2        <= ALUSrc ? Imm : w_fwd_b;
      r_sel        <= w_sel;
      r_store_data <= w_fwd_b;
      r_write_reg  <= CtrlIn[CI_REGDST] ? Rd : Rt;
      r_ctrl       <= {CtrlIn[CI_REGWRITE], CtrlIn[CI_MEMREAD], CtrlIn[2:1]};
    end
  end

  assign Stall     = w_stall;
  assign OutValid  = r_out_valid;
  assign Op1       = r_op1;
  assign Op2       = r_op2;
  assign Sel       = r_sel;
  assign StoreData = r_store_data;
  assign WriteReg  = r_write_reg;
  assign CtrlOut   = r_ctrl;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Performance counters; both wrap naturally at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)           r_stall_cnt <= r_stall_cnt + 32'd1;
      if (Flush && InValid)  r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_id_ex_stage;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, InValid, Flush, ALUSrc, MemRegWrite;
  logic [1:0]    ALUOp;
  logic [5:0]    Funct;
  logic [4:0]    CtrlIn;
  logic [AW-1:0] Rs, Rt, Rd, MemRd;
  logic [W-1:0]  RsData, RtData, Imm, ExResult, MemResult;
  logic          Stall, OutValid;
  logic [W-1:0]  Op1, Op2, StoreData;
  logic [3:0]    Sel, CtrlOut;
  logic [AW-1:0] WriteReg;
  logic [31:0]   StallCount, FlushCount;

  id_ex_stage #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .InValid(InValid), .Flush(Flush), .ALUOp(ALUOp),
    .Funct(Funct), .ALUSrc(ALUSrc), .CtrlIn(CtrlIn), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .RsData(RsData), .RtData(RtData), .Imm(Imm), .ExResult(ExResult),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemResult(MemResult),
    .Stall(Stall), .OutValid(OutValid), .Op1(Op1), .Op2(Op2), .Sel(Sel),
    .StoreData(StoreData), .WriteReg(WriteReg), .CtrlOut(CtrlOut),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, valid, flush, alusrc, mrw;
    bit [1:0]    aluop;
    bit [5:0]    funct;
    bit          regwrite, memread, memwrite, memtoreg, regdst;
    bit [AW-1:0] rs, rt, rd, mrd;
    bit [W-1:0]  rsd, rtd, imm, exr, memr;
  } stim_t;

  // What the stage holds, described as an instruction rather than as flops.
  typedef struct {
    bit          valid;
    bit [W-1:0]  op1, op2, sd;
    bit [3:0]    sel;
    bit [AW-1:0] dest;
    bit          regwrite, memread, memwrite, memtoreg;
  } instr_t;

  instr_t held;
  int unsigned exp_stalls, exp_flushes;
  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '{default: 0};
    return s;
  endfunction

  function automatic bit [3:0] alu_code(input bit [1:0] op, input bit [5:0] f);
    if (op == 2'b00) return 4'h2;
    if (op == 2'b01) return 4'h6;
    if (op == 2'b11) return 4'h1;
    if (f == 6'h20) return 4'h2;
    if (f == 6'h22) return 4'h6;
    if (f == 6'h24) return 4'h0;
    if (f == 6'h25) return 4'h1;
    if (f == 6'h2a) return 4'h7;
    if (f == 6'h18) return 4'h5;
    return 4'hf;
  endfunction

  // Value a source register should read given the in-flight writers.
  function automatic bit [W-1:0] source_value(input stim_t s, input bit [AW-1:0] r,
                                              input bit [W-1:0] rf);
    if (r == 0) return rf;
    if (held.valid && held.regwrite && !held.memread && held.dest == r) return s.exr;
    if (s.mrw && s.mrd == r) return s.memr;
    return rf;
  endfunction

  // One clock: drive, check Stall, model the edge, check registered outputs.
  task automatic step(input stim_t s, input bit chk_stall);
    instr_t nxt;
    bit     load_use, exp_stall;
    @(negedge clk);
    rst = s.rst; InValid = s.valid; Flush = s.flush; ALUOp = s.aluop;
    Funct = s.funct; ALUSrc = s.alusrc;
    CtrlIn = {s.regwrite, s.memread, s.memwrite, s.memtoreg, s.regdst};
    Rs = s.rs; Rt = s.rt; Rd = s.rd; RsData = s.rsd; RtData = s.rtd; Imm = s.imm;
    ExResult = s.exr; MemRegWrite = s.mrw; MemRd = s.mrd; MemResult = s.memr;
    #1;
    load_use  = held.valid && held.memread && held.dest != 0 &&
                (held.dest == s.rs ||
                 (held.dest == s.rt && (!s.alusrc || s.memwrite)));
    exp_stall = s.valid && load_use && !s.flush;
    if (chk_stall) check("stall", Stall, exp_stall);

    nxt = '{default: 0};
    if (!s.rst && s.valid && !s.flush && !exp_stall) begin
      nxt.valid    = 1;
      nxt.op1      = source_value(s, s.rs, s.rsd);
      nxt.sd       = source_value(s, s.rt, s.rtd);
      nxt.op2      = s.alusrc ? s.imm : nxt.sd;
      nxt.sel      = alu_code(s.aluop, s.funct);
      nxt.dest     = s.regdst ? s.rd : s.rt;
      nxt.regwrite = s.regwrite;
      nxt.memread  = s.memread;
      nxt.memwrite = s.memwrite;
      nxt.memtoreg = s.memtoreg;
    end
    if (s.rst) begin
      exp_stalls = 0; exp_flushes = 0;
    end else begin
      exp_stalls  += exp_stall;
      exp_flushes += (s.flush && s.valid);
    end

    @(posedge clk); #1;
    held = nxt;
    check("valid", OutValid, held.valid);
    check("op1", Op1, held.op1);
    check("op2", Op2, held.op2);
    check("sel", Sel, held.sel);
    check("store", StoreData, held.sd);
    check("wreg", WriteReg, held.dest);
    check("ctrl", CtrlOut, {held.regwrite, held.memread, held.memwrite, held.memtoreg});
`ifdef IDEX_PERF_CNT_EN
    check("stall_cnt", StallCount, exp_stalls);
    check("flush_cnt", FlushCount, exp_flushes);
`else
    check("stall_cnt", StallCount, 0);
    check("flush_cnt", FlushCount, 0);
`endif
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst      = ($urandom_range(0, 99) == 0);
    s.valid    = ($urandom_range(0, 9) != 0);
    s.flush    = ($urandom_range(0, 9) == 0);
    s.alusrc   = $urandom_range(0, 1);
    s.mrw      = $urandom_range(0, 1);
    s.aluop    = $urandom_range(0, 3);
    s.funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) :
                 (($urandom_range(0, 1) == 0) ? 6'h20 : 6'h2a);
    s.regwrite = $urandom_range(0, 1);
    s.memread  = ($urandom_range(0, 2) == 0);
    s.memwrite = ($urandom_range(0, 3) == 0);
    s.memtoreg = $urandom_range(0, 1);
    s.regdst   = $urandom_range(0, 1);
    s.rs       = AW'($urandom_range(0, 5));
    s.rt       = AW'($urandom_range(0, 5));
    s.rd       = AW'($urandom_range(0, 5));
    s.mrd      = AW'($urandom_range(0, 5));
    s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
    s.exr = $urandom; s.memr = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s, lw, haz;
    held = '{default: 0};
    exp_stalls = 0; exp_flushes = 0;

    // Reset for two cycles with random inputs.
    s = rand_stim(); s.rst = 1; step(s, 0);
    s = rand_stim(); s.rst = 1; step(s, 1);
    check("rst_valid", OutValid, 0);
    check("rst_op1", Op1, 0);

    // Plain R-type add.
    s = idle(); s.valid = 1; s.aluop = 2'b10; s.funct = 6'h20; s.rs = 1; s.rt = 2;
    s.rsd = 5; s.rtd = 7; s.regwrite = 1; s.regdst = 1; s.rd = 3;
    step(s, 1);
    check("t2_op1", Op1, 5);
    check("t2_op2", Op2, 7);
    check("t2_sel", Sel, 4'b0010);

    // EX beats MEM, then MEM alone.
    s = idle(); s.valid = 1; s.rs = 3; s.rsd = 0; s.exr = 12; s.mrw = 1; s.mrd = 3;
    s.memr = 99; s.alusrc = 1; s.imm = 4;
    step(s, 1);
    check("t3_ex_fwd", Op1, 12);
    step(s, 1);
    check("t3_mem_fwd", Op1, 99);

    // Load-use hazard: one stall, then MEM forwarding of the loaded value.
    lw = idle(); lw.valid = 1; lw.regwrite = 1; lw.memread = 1; lw.memtoreg = 1;
    lw.alusrc = 1; lw.rs = 1; lw.rt = 4; lw.imm = 16;
    step(lw, 1);
    haz = idle(); haz.valid = 1; haz.aluop = 2'b10; haz.funct = 6'h25; haz.rs = 4;
    haz.rt = 2; haz.rsd = 1; haz.rtd = 2;
    step(haz, 1);
    check("t4_bubble_valid", OutValid, 0);
    check("t4_bubble_ctrl", CtrlOut, 0);
    haz.mrw = 1; haz.mrd = 4; haz.memr = 32'h55;
    step(haz, 1);
    check("t4_op1", Op1, 32'h55);
    check("t4_sel", Sel, 4'b0001);

    // Same hazard with a flush: no stall, bubble captured.
    step(lw, 1);
    haz = idle(); haz.valid = 1; haz.flush = 1; haz.rs = 4;
    step(haz, 1);
    check("t5_bubble", OutValid, 0);

    // Register 0 never forwards; unknown funct decodes to 1111.
    s = idle(); s.valid = 1; s.regwrite = 1; s.regdst = 1; s.rd = 0;
    step(s, 1);
    s = idle(); s.valid = 1; s.aluop = 2'b10; s.funct = 6'b000111; s.rs = 0;
    s.rsd = 0; s.exr = 9;
    step(s, 1);
    check("t6_r0", Op1, 0);
    check("t6_sel", Sel, 4'hf);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) step(rand_stim(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
